// File: rtl/pool_feeder.sv
// Streams a feature map, channel by channel, from a read-latency-1 buffer into avg_pool.
// Optional POOL_FEEDER_PERF_EN adds a 32-bit busy-cycle counter output.
module pool_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_points,
  input  logic [CNT_WIDTH-1:0]  num_channels,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] newPointData,
  output logic                  newPointValid,
  output logic                  channelLast,
  input  logic                  poolDone,
  output logic                  busy,
`ifdef POOL_FEEDER_PERF_EN
  output logic [31:0]           cycle_count,
`endif
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_POOL, FINISH} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  np_q, nc_q, point, chan;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  drain_cnt;
  logic [1:0]            vld_pipe, last_pipe;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  rd_last;

  assign mem_rd_en     = (state == READ);
  assign mem_addr      = addr;
  assign busy          = (state != IDLE);
  assign newPointValid = vld_pipe[1];
  assign channelLast   = last_pipe[1];
  assign newPointData  = data_q;
  assign done          = done_q;
  assign rd_last       = mem_rd_en && (point == np_q - CNT_WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      np_q      <= '0;
      nc_q      <= '0;
      point     <= '0;
      chan      <= '0;
      addr      <= '0;
      drain_cnt <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= (state == FINISH);
      // stage 0: read issued, stage 1: rdata captured into the output register
      vld_pipe  <= {vld_pipe[0], mem_rd_en};
      last_pipe <= {last_pipe[0], rd_last};
      if (vld_pipe[0]) data_q <= mem_rdata;
      case (state)
        IDLE: if (start) begin
          addr  <= base_addr;
          np_q  <= num_points;
          nc_q  <= num_channels;
          point <= '0;
          chan  <= '0;
          state <= (num_points == '0 || num_channels == '0) ? FINISH : READ;
        end
        READ: begin
          // channels are contiguous, so the running address just keeps counting
          addr <= addr + ADDR_WIDTH'(1);
          if (point == np_q - CNT_WIDTH'(1)) begin
            point     <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            point <= point + CNT_WIDTH'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= WAIT_POOL;
        end
        WAIT_POOL: if (poolDone) begin
          if (chan == nc_q - CNT_WIDTH'(1)) begin
            state <= FINISH;
          end else begin
            chan  <= chan + CNT_WIDTH'(1);
            state <= READ;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POOL_FEEDER_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    cycle_count <= '0;
    else if (state == IDLE && start) cycle_count <= '0;
    else if (busy)                   cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pool_feeder.sv
// Directed bench for pool_feeder: buffer model returns data == address.
module tb_pool_feeder;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        poolDone = 1'b0;
  logic [15:0] base_addr = '0, num_points = '0, num_channels = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] newPointData;
  logic        newPointValid, channelLast, busy, done;
`ifdef POOL_FEEDER_PERF_EN
  logic [31:0] cycle_count;
`endif

  pool_feeder dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_points(num_points), .num_channels(num_channels), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .newPointData(newPointData),
    .newPointValid(newPointValid), .channelLast(channelLast), .poolDone(poolDone),
    .busy(busy),
`ifdef POOL_FEEDER_PERF_EN
    .cycle_count(cycle_count),
`endif
    .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_rd_en) mem_rdata <= {16'h0, mem_addr};

  int          rd_cyc[$], pt_cyc[$], done_cyc[$];
  logic [15:0] rd_addr[$];
  logic [31:0] pt_data[$];
  logic        pt_last[$];
  int          busy_cnt = 0;
  int          total = 0, bad = 0;

  always @(negedge clock) begin
    if (mem_rd_en) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(cyc); end
    if (newPointValid) begin
      pt_data.push_back(newPointData); pt_last.push_back(channelLast); pt_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cnt++;
  end

  task tick;
    @(posedge clock); #1;
  endtask

  task clear_q;
    rd_addr.delete(); rd_cyc.delete(); pt_data.delete(); pt_last.delete();
    pt_cyc.delete(); done_cyc.delete(); busy_cnt = 0;
  endtask

  // Drives one map; answers each channelLast with poolDone 3 cycles later.
  task automatic run_map(input logic [15:0] b, input logic [15:0] np, input logic [15:0] nc,
                         input bit noise, output int s);
    int n;
    base_addr = b; num_points = np; num_channels = nc; start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    if (np != 0 && nc != 0) begin
      for (int ch = 0; ch < int'(nc); ch++) begin
        n = 0;
        do begin
          tick(); n++;
          if (noise) begin start = 1'b1; base_addr = 16'h0777; poolDone = 1'b1; end
        end while (!channelLast && n < 100);
        total++;
        if (!channelLast) begin
          bad++; $display("FAIL run_map_last: ch=%0d channelLast=0 required=1 within 100 cycles", ch);
        end
        repeat (3) begin tick(); start = 1'b0; poolDone = 1'b0; base_addr = b; end
        poolDone = 1'b1; tick(); poolDone = 1'b0;
      end
    end
    n = 0;
    while (done_cyc.size() == 0 && n < 20) begin tick(); n++; end
    total++;
    if (done_cyc.size() == 0) begin
      bad++; $display("FAIL run_map_done: done count=0 required>=1 within 20 cycles");
    end
    repeat (3) tick();
  endtask

  task test_reset;
    #2;
    total++;
    if ({busy, done, mem_rd_en, newPointValid, channelLast, newPointData, mem_addr} !== '0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b done=%b rd=%b vld=%b last=%b data=%h addr=%h required all 0",
                      busy, done, mem_rd_en, newPointValid, channelLast, newPointData, mem_addr);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, done, mem_rd_en, newPointValid} !== 4'b0) begin
      bad++; $display("FAIL reset_release_idle: got busy=%b done=%b rd=%b vld=%b required 0", busy, done, mem_rd_en, newPointValid);
    end
  endtask

  task automatic test_basic;
    int s;
    clear_q();
    run_map(16'h0010, 16'd4, 16'd1, 1'b0, s);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rd_addr.size() || rd_addr[i] !== 16'h0010 + 16'(i) || rd_cyc[i] !== s + 1 + i) begin
        bad++; $display("FAIL basic_read[%0d]: got n=%0d required addr=%h cyc=%0d", i, rd_addr.size(), 16'h10 + i, s + 1 + i);
      end
      total++;
      if (i >= pt_data.size() || pt_data[i] !== 32'h10 + 32'(i) || pt_cyc[i] !== s + 3 + i || pt_last[i] !== (i == 3)) begin
        bad++; $display("FAIL basic_point[%0d]: got n=%0d required data=%h cyc=%0d last=%0d", i, pt_data.size(), 32'h10 + i, s + 3 + i, i == 3);
      end
    end
    total++;
    if (rd_addr.size() != 4 || pt_data.size() != 4) begin
      bad++; $display("FAIL basic_counts: got reads=%0d points=%0d required 4 and 4", rd_addr.size(), pt_data.size());
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] !== s + 11) begin
      bad++; $display("FAIL basic_done: got n=%0d required one done at cyc %0d", done_cyc.size(), s + 11);
    end
`ifdef POOL_FEEDER_PERF_EN
    total++;
    if (cycle_count !== 32'd10 || busy_cnt != 10) begin
      bad++; $display("FAIL perf_count: got cycle_count=%0d busy_cycles=%0d required 10", cycle_count, busy_cnt);
    end
`endif
  endtask

  task automatic check_two_level(input string name, input logic [15:0] b, input int nch, input int s, input int done_at);
    for (int i = 0; i < 3 * nch; i++) begin
      total++;
      if (i >= rd_addr.size() || rd_addr[i] !== b + 16'(i) || rd_cyc[i] !== s + 1 + 8 * (i / 3) + (i % 3)) begin
        bad++; $display("FAIL %s_read[%0d]: got n=%0d required addr=%h cyc=%0d", name, i, rd_addr.size(), b + i, s + 1 + 8 * (i / 3) + (i % 3));
      end
      total++;
      if (i >= pt_data.size() || pt_data[i] !== {16'h0, b + 16'(i)} || pt_last[i] !== (i % 3 == 2)) begin
        bad++; $display("FAIL %s_point[%0d]: got n=%0d required data=%h last=%0d", name, i, pt_data.size(), b + i, i % 3 == 2);
      end
    end
    total++;
    if (rd_addr.size() != 3 * nch || done_cyc.size() != 1 || done_cyc[0] !== done_at) begin
      bad++; $display("FAIL %s_done: got reads=%0d dones=%0d required reads=%0d one done at cyc %0d",
                      name, rd_addr.size(), done_cyc.size(), 3 * nch, done_at);
    end
  endtask

  task automatic test_multi;
    int s;
    clear_q();
    run_map(16'h0000, 16'd3, 16'd3, 1'b0, s);
    check_two_level("multi", 16'h0000, 3, s, s + 26);
  endtask

  task automatic test_ignore;
    int s;
    clear_q();
    run_map(16'h0020, 16'd3, 16'd2, 1'b1, s);
    check_two_level("ignore", 16'h0020, 2, s, s + 18);
  endtask

  task automatic test_zero;
    int s;
    for (int k = 0; k < 2; k++) begin
      clear_q();
      if (k == 0) run_map(16'h0030, 16'd0, 16'd5, 1'b0, s);
      else        run_map(16'h0030, 16'd3, 16'd0, 1'b0, s);
      total++;
      if (rd_addr.size() != 0 || pt_data.size() != 0) begin
        bad++; $display("FAIL zero_quiet[%0d]: got reads=%0d points=%0d required 0", k, rd_addr.size(), pt_data.size());
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] !== s + 2) begin
        bad++; $display("FAIL zero_done[%0d]: got n=%0d required one done at cyc %0d", k, done_cyc.size(), s + 2);
      end
    end
  endtask

  task automatic test_wrap;
    int s;
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_q();
    run_map(16'hFFFE, 16'd4, 16'd1, 1'b0, s);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rd_addr.size() || rd_addr[i] !== exp_a[i] || pt_data[i] !== {16'h0, exp_a[i]}) begin
        bad++; $display("FAIL wrap[%0d]: got n=%0d required addr=data=%h", i, rd_addr.size(), exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    base_addr = 16'h0040; num_points = 16'd8; num_channels = 16'd1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0; #1;
    total++;
    if ({busy, done, mem_rd_en, newPointValid, channelLast, newPointData, mem_addr} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs: got busy=%b rd=%b vld=%b data=%h addr=%h required all 0",
                      busy, mem_rd_en, newPointValid, newPointData, mem_addr);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    clear_q();
    repeat (10) tick();
    total++;
    if (rd_addr.size() != 0 || pt_data.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_idle: got reads=%0d points=%0d dones=%0d busy=%b required 0",
                      rd_addr.size(), pt_data.size(), done_cyc.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_zero();
    test_ignore();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pool_feeder.md
POOL_FEEDER -- requirements
Module: pool_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: point data width.
REQ-002 Parameter ADDR_WIDTH, default 16: feature-buffer address width.
REQ-003 Parameter CNT_WIDTH, default 16: width of the point and channel counts.
REQ-004 Ports SHALL be, one per line (name  direction  width  meaning):
- clock  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to stream a feature map.
- base_addr  in  ADDR_WIDTH  first buffer address, sampled on accepted start.
- num_points  in  CNT_WIDTH  points per channel, sampled on accepted start.
- num_channels  in  CNT_WIDTH  channel count, sampled on accepted start.
- mem_rd_en  out  1  buffer read strobe.
- mem_addr  out  ADDR_WIDTH  buffer read address.
- mem_rdata  in  DATA_WIDTH  buffer read data, valid one cycle after mem_rd_en.
- newPointData  out  DATA_WIDTH  streamed point to avg_pool.
- newPointValid  out  1  newPointData qualifier.
- channelLast  out  1  high with the final point of each channel.
- poolDone  in  1  avg_pool done pulse, channel result complete.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, whole map finished.

Function
REQ-005 FSM states SHALL be IDLE, READ, DRAIN, WAIT_POOL and FINISH.
REQ-006 In IDLE, start SHALL latch base_addr, num_points and num_channels, clear the point and channel counters, and move to READ; start outside IDLE SHALL be ignored.
REQ-007 If start arrives with num_points==0 or num_channels==0, the block SHALL go directly to FINISH with no reads issued.
REQ-008 In READ, mem_rd_en SHALL be 1 every cycle, with mem_addr = base + channel*num_points + point (modulo 2^ADDR_WIDTH); after the read with point==num_points-1 the state SHALL be DRAIN.
REQ-009 Output latency: a read issued at cycle t SHALL give newPointValid=1 and newPointData=mem_rdata(t+1) at cycle t+2 (registered outputs); points SHALL stream back-to-back with no gaps inside a channel.
REQ-010 channelLast SHALL be 1 only together with the newPointValid of point num_points-1.
REQ-011 DRAIN SHALL last exactly 2 cycles so the final point leaves the block, then the state SHALL be WAIT_POOL.
REQ-012 In WAIT_POOL, poolDone=1 SHALL advance the state to READ for the next channel, or to FINISH when channel==num_channels-1; poolDone outside WAIT_POOL SHALL be ignored.
REQ-013 FINISH SHALL assert done for exactly one cycle and return to IDLE; start in that cycle SHALL be ignored.
REQ-014 mem_rd_en, newPointValid and channelLast SHALL be 0 in every state and cycle not named above.
REQ-015 Address arithmetic SHALL use a running address register incremented by 1, not a multiplier, with wrap-around at 2^ADDR_WIDTH.

Reset
REQ-016 reset_n low SHALL asynchronously force IDLE and clear all counters, the address register and the data register.
REQ-017 During reset every output SHALL be 0 (busy=0, done=0, mem_rd_en=0, newPointValid=0, channelLast=0, newPointData=0, mem_addr=0).
REQ-018 Reset asserted mid-stream SHALL abort the stream; after reset release the block SHALL emit nothing until a new start.

Configuration
REQ-019 With POOL_FEEDER_PERF_EN defined, the block SHALL add output cycle_count (32 bits).
- cycle_count clears on accepted start and increments every cycle while busy=1.
- cycle_count holds its value after done and resets to 0.
REQ-020 Without POOL_FEEDER_PERF_EN, cycle_count SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 Basic stream.
- Stimulus: base=0x10, points=4, channels=1, buffer[a]=a; poolDone 3 cycles after channelLast.
- Required: reads at 0x10..0x13; newPointData 0x10..0x13 on consecutive cycles, first one 3 cycles after start; channelLast on 0x13; done one cycle after poolDone is sampled.
REQ-022 Multi-channel.
- Stimulus: points=3, channels=3, base=0.
- Required: addresses 0..8, three bursts of 3 points; no read until poolDone for the previous channel; exactly one done.
REQ-023 Zero sizes.
- Stimulus: num_points=0, then num_channels=0.
- Required: each start gives done 2 cycles later; mem_rd_en and newPointValid never 1.
REQ-024 Ignored events.
- Stimulus: start during READ; poolDone during READ and DRAIN.
- Required: no restart, no early channel advance; address sequence unchanged.
REQ-025 Reset and wrap.
- Stimulus: reset_n low mid-burst.
- Required: outputs 0 immediately, idle after release.
- Stimulus: base=0xFFFE, points=4.
- Required: addresses FFFE, FFFF, 0000, 0001.
REQ-026 Perf counter.
- Stimulus: with POOL_FEEDER_PERF_EN, repeat REQ-021.
- Required: cycle_count equals the cycles counted with busy=1.
